// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants and state encoding for the RV32I fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] C_INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_register.sv
`default_nettype none
// ============================================================================
// Module      : pc_register
// Description : Program-counter register with synchronous reset and load enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_register #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [XLEN-1:0] d,
    output logic [XLEN-1:0] q
);

    logic [XLEN-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_PC;
        end else if (load) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction fetch: PC, single-outstanding imem handshake,
//               IF/ID pipeline register with stall and redirect/flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            imem_resp_ready,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_inst
);

    localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] C_INST_BYTES = XLEN'(4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_pc_next;
    logic            w_pc_load;
    logic            w_if_id_load;
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_pc;
    logic [31:0]     r_if_id_inst;
    logic            w_slot_free;
    logic            w_consume;
    logic            w_req_fire;
    logic            w_resp_fire;

    assign w_slot_free = !r_if_id_valid || !stall;
    assign w_consume   = r_if_id_valid && !stall;

    // Handshake outputs are forced low during reset so a stale state cannot leak out.
    assign imem_req_valid  = !reset && (r_state == S_REQ) && w_slot_free && !redirect_valid;
    assign imem_resp_ready = !reset && (((r_state == S_WAIT) && w_slot_free) || (r_state == S_DROP));
    assign imem_req_addr   = w_pc;

    assign w_req_fire  = imem_req_valid && imem_req_ready;
    assign w_resp_fire = imem_resp_valid && imem_resp_ready;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk   (clk),
        .reset (reset),
        .load  (w_pc_load),
        .d     (w_pc_next),
        .q     (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_load    = 1'b0;
        w_pc_next    = w_pc;
        w_if_id_load = 1'b0;
        if (redirect_valid) begin
            w_pc_load = 1'b1;
            w_pc_next = redirect_pc & C_ALIGN_MASK;
            // An in-flight response must still be drained before the next request.
            case (r_state)
                S_WAIT:  w_state_next = w_resp_fire ? S_REQ : S_DROP;
                S_DROP:  w_state_next = w_resp_fire ? S_REQ : S_DROP;
                default: w_state_next = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp_fire) begin
                        w_if_id_load = 1'b1;
                        w_pc_load    = 1'b1;
                        w_pc_next    = r_fetch_pc + C_INST_BYTES;
                        w_state_next = S_REQ;
                    end
                end
                S_DROP: begin
                    if (w_resp_fire) begin
                        w_state_next = S_REQ;
                    end
                end
                default: w_state_next = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= '0;
        end else if (w_req_fire) begin
            r_fetch_pc <= w_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_inst  <= C_INST_NOP;
        end else if (redirect_valid) begin
            r_if_id_valid <= 1'b0;
            r_if_id_inst  <= C_INST_NOP;
        end else if (w_if_id_load) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_fetch_pc;
            r_if_id_inst  <= imem_resp_data;
        end else if (w_consume) begin
            r_if_id_valid <= 1'b0;
        end
    end

    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_inst  = r_if_id_inst;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (C_RESET_PC),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_ready (imem_resp_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_inst      (if_id_inst)
    );

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level model: one fetch in flight, possibly marked as doomed by a flush.
    bit          m_known = 0;
    bit          m_out   = 0;
    bit          m_doom  = 0;
    bit          m_ifv   = 0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_faddr = 32'h0;
    logic [31:0] m_ifpc  = 32'h0;
    logic [31:0] m_inst  = C_NOP;

    // Memory environment with programmable response latency.
    bit          mem_pend = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'h0;
    int          next_lat = 0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'hFE00_0EE3;
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic a_rst, input logic a_stall, input logic a_redir,
                         input logic [31:0] a_rpc, input logic a_rdy);
        logic        e_reqv, e_respr, slot, qf_m, rf_m, qf_d, rf_d, ld;
        logic [31:0] addr_d;
        reset           = a_rst;
        stall           = a_stall;
        redirect_valid  = a_redir;
        redirect_pc     = a_rpc;
        imem_req_ready  = a_rdy;
        imem_resp_valid = mem_pend && (mem_cnt == 0);
        imem_resp_data  = mem_pend ? mem_fn(mem_addr) : $urandom;
        #1;
        slot    = !m_ifv || !a_stall;
        e_reqv  = !a_rst && !m_out && slot && !a_redir;
        e_respr = !a_rst && m_out && (m_doom || slot);
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, e_reqv});
        if (e_reqv) check("req_addr", imem_req_addr, m_pc);
        check("resp_ready", {31'b0, imem_resp_ready}, {31'b0, e_respr});
        if (m_known) begin
            check("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_ifv});
            check("if_id_pc", if_id_pc, m_ifpc);
            check("if_id_inst", if_id_inst, m_inst);
        end
        if (!a_rst) check("resp_without_request", {31'b0, imem_resp_valid && !m_out}, 32'h0);
        qf_m   = e_reqv && a_rdy;
        rf_m   = e_respr && imem_resp_valid;
        qf_d   = imem_req_valid && a_rdy;
        rf_d   = imem_resp_valid && imem_resp_ready;
        addr_d = imem_req_addr;
        @(posedge clk);
        if (a_rst) begin
            mem_pend = 0;
        end else begin
            if (rf_d) mem_pend = 0;
            if (qf_d) begin
                mem_pend = 1;
                mem_addr = addr_d;
                mem_cnt  = next_lat;
            end else if (mem_pend && mem_cnt > 0) begin
                mem_cnt--;
            end
        end
        if (a_rst) begin
            m_known = 1; m_out = 0; m_doom = 0; m_ifv = 0;
            m_ifpc  = 32'h0; m_inst = C_NOP; m_pc = C_RESET_PC;
        end else if (a_redir) begin
            m_pc   = a_rpc & 32'hFFFF_FFFC;
            m_ifv  = 0;
            m_inst = C_NOP;
            if (m_out) begin
                if (rf_m) begin m_out = 0; m_doom = 0; end
                else m_doom = 1;
            end
        end else begin
            ld = rf_m && !m_doom;
            if (rf_m) begin m_out = 0; m_doom = 0; end
            if (qf_m) begin m_out = 1; m_doom = 0; m_faddr = m_pc; end
            if (ld) begin
                m_ifv  = 1;
                m_ifpc = m_faddr;
                m_inst = mem_fn(m_faddr);
                m_pc   = m_faddr + 32'd4;
            end else if (m_ifv && !a_stall) begin
                m_ifv = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_to_wait();
        for (int i = 0; i < 20 && !(m_out && !m_doom); i++) cycle(0, 0, 0, 32'h0, 1);
        check("reach_wait_timeout", {31'b0, m_out && !m_doom}, 32'h1);
    endtask

    initial begin
        reset = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        @(negedge clk);

        // Reset then zero-latency fetch of the first two words
        next_lat = 0;
        cycle(1, 0, 0, 32'h0, 1);
        cycle(1, 0, 0, 32'h0, 1);
        check("post_reset_inst", if_id_inst, C_NOP);
        check("first_req_addr", imem_req_addr, C_RESET_PC);
        repeat (4) cycle(0, 0, 0, 32'h0, 1);
        check("second_inst_pc", if_id_pc, 32'h4);
        check("second_inst", if_id_inst, 32'hFE00_0EE3);

        // Stall while IF/ID holds a live instruction
        for (int i = 0; i < 10 && !m_ifv; i++) cycle(0, 0, 0, 32'h0, 1);
        repeat (3) cycle(0, 1, 0, 32'h0, 1);
        repeat (4) cycle(0, 0, 0, 32'h0, 1);

        // Redirect from S_WAIT with a late response drained through S_DROP
        next_lat = 2;
        run_to_wait();
        cycle(0, 0, 1, 32'h0000_0102, 1);
        for (int i = 0; i < 10 && m_out; i++) cycle(0, 0, 0, 32'h0, 1);
        check("redirect_req_addr", imem_req_addr, 32'h0000_0100);
        repeat (4) cycle(0, 0, 0, 32'h0, 1);

        // Redirect coinciding with the response handshake
        next_lat = 0;
        run_to_wait();
        cycle(0, 0, 1, 32'h0000_0240, 1);
        check("flush_inst", if_id_inst, C_NOP);
        check("no_drop_req_addr", imem_req_addr, 32'h0000_0240);
        repeat (3) cycle(0, 0, 0, 32'h0, 1);

        // Redirect to the top of the address space and wrap
        run_to_wait();
        cycle(0, 1, 1, 32'hFFFF_FFFE, 1);
        for (int i = 0; i < 10 && !(m_ifv && m_ifpc == 32'hFFFF_FFFC); i++) cycle(0, 0, 0, 32'h0, 1);
        check("wrap_req_addr", imem_req_addr, 32'h0000_0000);
        repeat (2) cycle(0, 0, 0, 32'h0, 1);

        // Reset in the middle of a transaction
        next_lat = 2;
        run_to_wait();
        cycle(1, 0, 0, 32'h0, 1);
        check("mid_reset_valid", {31'b0, if_id_valid}, 32'h0);
        check("mid_reset_inst", if_id_inst, C_NOP);
        check("mid_reset_req_addr", imem_req_addr, C_RESET_PC);
        repeat (3) cycle(0, 0, 0, 32'h0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            next_lat = $urandom_range(0, 2);
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 10), $urandom, ($urandom_range(0, 99) < 70));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
